ascon_permutation_ctrl: RTL and testbench



---
 rtl/ascon_permutation_ctrl.sv | 88 ++++++++
 tb/tb_ascon_permutation_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_ctrl.sv
// Ascon p^n sequencer: holds the 320-bit state and drives an external
// single-round datapath once per clock, with valid/ready request and result channels.
package ascon_pkg;
    typedef logic [4:0][63:0] t_state_array;
endpackage

module ascon_permutation_ctrl
    import ascon_pkg::*;
#(
    parameter int P_MAX_ROUNDS = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_start_valid,
    output logic         o_start_ready,
    input  logic [3:0]   i_rounds,
    input  t_state_array i_state,
    output t_state_array o_round_state,
    output logic [7:0]   o_round_const,
    input  t_state_array i_round_state,
    output logic         o_busy,
    output logic         o_done_valid,
    input  logic         i_done_ready,
    output t_state_array o_state
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [3:0] MAX_R  = 4'(P_MAX_ROUNDS);
    localparam logic [3:0] LAST_R = 4'(P_MAX_ROUNDS - 1);

    fsm_t         fsm, fsm_nx;
    t_state_array st, st_nx;
    logic [3:0]   rnd, rnd_nx;
    logic [3:0]   n_eff;

    // Requests above the full permutation length saturate to p^12.
    always_comb n_eff = (i_rounds > MAX_R) ? MAX_R : i_rounds;

    always_comb begin
        fsm_nx        = fsm;
        st_nx         = st;
        rnd_nx        = rnd;
        o_start_ready = 1'b0;
        o_busy        = 1'b0;
        o_done_valid  = 1'b0;
        o_round_const = 8'h00;
        case (fsm)
            IDLE: begin
                o_start_ready = 1'b1;
                if (i_start_valid) begin
                    st_nx  = i_state;
                    // p^n uses the last n rounds of p^12, so start mid-schedule.
                    rnd_nx = MAX_R - n_eff;
                    fsm_nx = (n_eff == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                o_busy        = 1'b1;
                o_round_const = {4'hF - rnd, rnd};
                st_nx         = i_round_state;
                if (rnd == LAST_R) fsm_nx = DONE;
                else               rnd_nx = rnd + 4'd1;
            end
            DONE: begin
                o_done_valid = 1'b1;
                if (i_done_ready) fsm_nx = IDLE;
            end
            default: fsm_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm <= IDLE;
            st  <= '0;
            rnd <= '0;
        end else begin
            fsm <= fsm_nx;
            st  <= st_nx;
            rnd <= rnd_nx;
        end
    end

    assign o_round_state = st;
    assign o_state       = st;

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Bench for ascon_permutation_ctrl: supplies the Ascon round as the external
// datapath and compares against a whole-permutation reference model.
module tb_ascon_permutation_ctrl;
    import ascon_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         i_start_valid;
    logic         o_start_ready;
    logic [3:0]   i_rounds;
    t_state_array i_state;
    t_state_array o_round_state;
    logic [7:0]   o_round_const;
    t_state_array i_round_state;
    logic         o_busy;
    logic         o_done_valid;
    logic         i_done_ready;
    t_state_array o_state;

    int passed = 0;
    int total  = 0;

    logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    ascon_permutation_ctrl #(.P_MAX_ROUNDS(12)) dut (
        .clock(clock), .reset(reset),
        .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
        .i_rounds(i_rounds), .i_state(i_state),
        .o_round_state(o_round_state), .o_round_const(o_round_const),
        .i_round_state(i_round_state), .o_busy(o_busy),
        .o_done_valid(o_done_valid), .i_done_ready(i_done_ready),
        .o_state(o_state)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
    function automatic t_state_array ascon_round(input t_state_array s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        t_state_array r;
        x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return r;
    endfunction

    assign i_round_state = ascon_round(o_round_state, o_round_const);

    function automatic int sat_rounds(input int n);
        return (n > 12) ? 12 : n;
    endfunction

    // p^n applies the last n constants of the p^12 schedule.
    function automatic t_state_array perm(input t_state_array s, input int n);
        t_state_array r = s;
        for (int i = 12 - sat_rounds(n); i < 12; i++) r = ascon_round(r, rc_tab[i]);
        return r;
    endfunction

    function automatic t_state_array rand_state();
        t_state_array r;
        for (int i = 0; i < 5; i++) r[i] = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Full request/result transaction with `hold` cycles of result backpressure.
    task automatic do_perm(input int n, input t_state_array s, input int hold, input string tag);
        t_state_array exp_s;
        int ne;
        ne = sat_rounds(n);
        exp_s = perm(s, n);
        i_start_valid = 1'b1; i_rounds = 4'(n); i_state = s; i_done_ready = 1'b0;
        total++;
        if (o_start_ready !== 1'b1) $display("FAIL %s ready_before_accept got=%b want=1", tag, o_start_ready);
        else passed++;
        step();
        i_start_valid = 1'b0; i_rounds = 4'($urandom_range(0, 15)); i_state = rand_state();
        for (int k = 0; k < ne; k++) begin
            total++;
            if (o_busy !== 1'b1 || o_done_valid !== 1'b0 || o_round_const !== rc_tab[12 - ne + k])
                $display("FAIL %s run_cycle%0d got busy=%b done=%b rc=%h want busy=1 done=0 rc=%h",
                         tag, k, o_busy, o_done_valid, o_round_const, rc_tab[12 - ne + k]);
            else passed++;
            step();
        end
        total++;
        if (o_done_valid !== 1'b1 || o_busy !== 1'b0 || o_round_const !== 8'h00 || o_start_ready !== 1'b0)
            $display("FAIL %s done_flags got done=%b busy=%b rc=%h ready=%b want 1 0 00 0",
                     tag, o_done_valid, o_busy, o_round_const, o_start_ready);
        else passed++;
        total++;
        if (o_state !== exp_s || o_round_state !== exp_s)
            $display("FAIL %s result got=%h want=%h", tag, o_state, exp_s);
        else passed++;
        for (int h = 0; h < hold; h++) begin
            i_start_valid = 1'b1; i_state = rand_state(); i_rounds = 4'd6;
            step();
            total++;
            if (o_done_valid !== 1'b1 || o_start_ready !== 1'b0 || o_state !== exp_s)
                $display("FAIL %s hold%0d got done=%b ready=%b state=%h want done=1 ready=0 state=%h",
                         tag, h, o_done_valid, o_start_ready, o_state, exp_s);
            else passed++;
        end
        i_start_valid = 1'b0;
        i_done_ready = 1'b1;
        step();
        i_done_ready = 1'b0;
        total++;
        if (o_start_ready !== 1'b1 || o_done_valid !== 1'b0 || o_busy !== 1'b0)
            $display("FAIL %s back_to_idle got ready=%b done=%b busy=%b want 1 0 0",
                     tag, o_start_ready, o_done_valid, o_busy);
        else passed++;
    endtask

    task automatic test_reset();
        t_state_array s;
        reset = 1'b1; i_start_valid = 1'b1; i_rounds = 4'd0; i_done_ready = 1'b0;
        i_state = rand_state();
        repeat (3) step();
        total++;
        if (o_start_ready !== 1'b1 || o_done_valid !== 1'b0 || o_busy !== 1'b0 ||
            o_round_const !== 8'h00 || o_state !== '0 || o_round_state !== '0)
            $display("FAIL reset_values got ready=%b done=%b busy=%b rc=%h state=%h",
                     o_start_ready, o_done_valid, o_busy, o_round_const, o_state);
        else passed++;
        // Request is held valid across release: first edge after release must take it.
        s = rand_state();
        i_state = s;
        reset = 1'b0;
        step();
        i_start_valid = 1'b0;
        total++;
        if (o_done_valid !== 1'b1 || o_state !== s)
            $display("FAIL reset_first_accept got done=%b state=%h want done=1 state=%h",
                     o_done_valid, o_state, s);
        else passed++;
        i_done_ready = 1'b1;
        step();
        i_done_ready = 1'b0;
    endtask

    task automatic test_p12_zero();
        do_perm(12, '0, 0, "p12_zero");
    endtask

    task automatic test_init_p6_p8();
        t_state_array s;
        s[0] = 64'h80400c0600000000;
        s[1] = {$urandom(), $urandom()}; s[2] = {$urandom(), $urandom()};
        s[3] = {$urandom(), $urandom()}; s[4] = {$urandom(), $urandom()};
        do_perm(6, s, 0, "p6_init");
        do_perm(8, s, 0, "p8_init");
        do_perm(12, s, 0, "p12_init");
    endtask

    task automatic test_backpressure();
        do_perm(8, rand_state(), 5, "backpressure");
        // Request waiting from the hold phase is taken right after the handshake.
        i_start_valid = 1'b1; i_rounds = 4'd6; i_state = rand_state();
        step();
        i_start_valid = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_round_const !== 8'h96)
            $display("FAIL resume_accept got busy=%b rc=%h want busy=1 rc=96", o_busy, o_round_const);
        else passed++;
        for (int k = 0; k < 40 && o_done_valid !== 1'b1; k++) step();
        i_done_ready = 1'b1;
        step();
        i_done_ready = 1'b0;
    endtask

    task automatic test_boundary();
        do_perm(0, rand_state(), 0, "rounds0");
        do_perm(15, rand_state(), 0, "rounds15");
        do_perm(13, '0, 1, "rounds13");
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            do_perm(int'($urandom_range(0, 15)), rand_state(), int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_back_to_back();
        int cnt;
        i_done_ready = 1'b1; i_start_valid = 1'b1; i_rounds = 4'd8; i_state = rand_state();
        step();
        cnt = 0;
        while (o_start_ready !== 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
        i_start_valid = 1'b0;
        total++;
        if (cnt + 1 !== 10)
            $display("FAIL back_to_back_period got=%0d want=10", cnt + 1);
        else passed++;
        i_done_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        i_start_valid = 1'b1; i_rounds = 4'd12; i_state = rand_state();
        step();
        i_start_valid = 1'b0;
        repeat (5) step();
        total++;
        if (o_busy !== 1'b1 || o_round_const !== 8'hA5)
            $display("FAIL midrun_round5 got busy=%b rc=%h want busy=1 rc=a5", o_busy, o_round_const);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_state !== '0 || o_done_valid !== 1'b0 || o_start_ready !== 1'b1)
            $display("FAIL midrun_abort got busy=%b done=%b ready=%b state=%h",
                     o_busy, o_done_valid, o_start_ready, o_state);
        else passed++;
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (o_done_valid === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) $display("FAIL midrun_no_result got done_pulse=1 want 0");
        else passed++;
        do_perm(12, rand_state(), 0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_p12_zero();
        test_init_p6_p8();
        test_backpressure();
        test_boundary();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
